agc_relay_driver: RTL

Relay sequencing stage that sits directly downstream of `auto_gain_control`. It consumes that block's `relay_ctrl` gain-range request and `stable` flag, and drives the four gain-range relay coils with break-before-make sequencing, a settle blank-out and a minimum hold time. It reports which gain range is applied and when ADC samples taken at that gain are trustworthy.

---
 rtl/agc_relay_driver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/agc_relay_driver.sv
// agc_relay_driver: drives the four gain-range relay coils requested by
// auto_gain_control with break-before-make sequencing, a settle blank-out
// and a minimum hold time, and reports when samples at the applied gain
// are trustworthy.
// Optional feature: define AGC_RELAY_STATS_EN to build the saturating
// switch counter; otherwise switch_cnt is tied to zero.
module agc_relay_driver #(
   parameter int GAP_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 1000,
   parameter int HOLD_CYCLES   = 2000
) (
   input  logic        adc_clk,
   input  logic        rst,
   input  logic [1:0]  relay_ctrl,
   input  logic        stable,
   output logic [3:0]  relay_coil,
   output logic [1:0]  gain_idx,
   output logic        gain_valid,
   output logic        gain_locked,
   output logic        busy,
   output logic [15:0] switch_cnt
);

   localparam int MAX_CYCLES =
      (GAP_CYCLES > SETTLE_CYCLES)
         ? ((GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES)
         : ((SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES);
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   // The counter holds the number of cycles still to spend in the current
   // state, including the present one; the state is left when it reads 1.
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_GAP    = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BREAK  = 3'd1,
      MAKE   = 3'd2,
      SETTLE = 3'd3,
      HOLD   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       target_q, target_d;
   logic [1:0]       gain_idx_q, gain_idx_d;
   logic [1:0]       req_q;
   logic             stable_q;
   logic [3:0]       coil_q, coil_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             locked_q;

   // Input register: the FSM only ever looks at the registered request.
   always_ff @(posedge adc_clk or posedge rst) begin
      if (rst) begin
         req_q    <= 2'd0;
         stable_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments in clocked blocks so every register
         // samples the values from before the edge, independent of order.
         req_q    <= relay_ctrl;
         stable_q <= stable;
      end
   end

   // State register plus registered outputs; reset lands in SETTLE at index 0.
   always_ff @(posedge adc_clk or posedge rst) begin
      if (rst) begin
         state_q    <= SETTLE;
         cnt_q      <= CNT_SETTLE;
         target_q   <= 2'd0;
         gain_idx_q <= 2'd0;
         coil_q     <= 4'b0001;
         valid_q    <= 1'b0;
         busy_q     <= 1'b1;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         target_q   <= target_d;
         gain_idx_q <= gain_idx_d;
         coil_q     <= coil_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         locked_q   <= valid_d & stable_q;
      end
   end

   // Next-state logic: sequence IDLE -> BREAK -> MAKE -> SETTLE -> HOLD.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      target_d   = target_q;
      gain_idx_d = gain_idx_q;
      unique case (state_q)
         IDLE: begin
            if (req_q != gain_idx_q) begin
               target_d = req_q;
               state_d  = BREAK;
               cnt_d    = CNT_GAP;
            end
         end
         BREAK: begin
            if (cnt_q == CNT_ONE) begin
               state_d    = MAKE;
               gain_idx_d = target_q;
               cnt_d      = CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         MAKE: begin
            state_d = SETTLE;
            cnt_d   = CNT_SETTLE;
         end
         SETTLE: begin
            if (cnt_q == CNT_ONE) begin
               state_d = HOLD;
               cnt_d   = CNT_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         HOLD: begin
            if (cnt_q == CNT_ONE) begin
               state_d = IDLE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            // Illegal encoding: fall back to re-settling the current coil.
            state_d = SETTLE;
            cnt_d   = CNT_SETTLE;
         end
      endcase
   end

   // Output decode from the next state so the outputs leave a register.
   always_comb begin
      coil_d  = (state_d == BREAK) ? 4'b0000 : (4'b0001 << gain_idx_d);
      valid_d = (state_d == HOLD) || (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

`ifdef AGC_RELAY_STATS_EN
   logic [15:0] switch_cnt_q;

   // Count completed makes, saturating; only reset clears it.
   always_ff @(posedge adc_clk or posedge rst) begin
      if (rst) begin
         switch_cnt_q <= 16'd0;
      end else if ((state_q == BREAK) && (state_d == MAKE) &&
                   (switch_cnt_q != 16'hFFFF)) begin
         switch_cnt_q <= switch_cnt_q + 16'd1;
      end
   end

   assign switch_cnt = switch_cnt_q;
`else
   assign switch_cnt = 16'd0;
`endif

   assign relay_coil  = coil_q;
   assign gain_idx    = gain_idx_q;
   assign gain_valid  = valid_q;
   assign gain_locked = locked_q;
   assign busy        = busy_q;

endmodule
